// File: rtl/phase_controller_pkg.sv
// Shared types and constants for the tinycpu phase controller:
// controller state encoding, phase encodings and small state decode helpers.
package phase_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_WB       = 3'd5,
    ST_HALT     = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

  localparam logic [1:0] PHASE_FETCH  = 2'd0;
  localparam logic [1:0] PHASE_DECODE = 2'd1;
  localparam logic [1:0] PHASE_EXEC   = 2'd2;
  localparam logic [1:0] PHASE_WB     = 2'd3;

  // Idle, halt and fault report the fetch phase so the core sits at a boundary.
  function automatic logic [1:0] phase_of(input state_e s);
    case (s)
      ST_DECODE:            return PHASE_DECODE;
      ST_EXEC, ST_MEM_WAIT: return PHASE_EXEC;
      ST_WB:                return PHASE_WB;
      default:              return PHASE_FETCH;
    endcase
  endfunction

  // States that hold a memory request open.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/phase_controller_if.sv
// Handshake bundle between the phase controller and the rest of the core:
// memory request/acknowledge, decoded instruction flags, write strobes, phase.
interface phase_controller_if;
  logic       mem_req;
  logic       mem_ack;
  logic       is_load_store;
  logic       is_halt;
  logic       ir_we;
  logic       reg_we;
  logic       pc_we;
  logic [1:0] phase;

  modport master (
    output mem_req, ir_we, reg_we, pc_we, phase,
    input  mem_ack, is_load_store, is_halt
  );

  modport slave (
    input  mem_req, ir_we, reg_we, pc_we, phase,
    output mem_ack, is_load_store, is_halt
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter. Counts cycles with an open, unacknowledged
// request and flags a timeout on the cycle whose count would reach MEM_TIMEOUT,
// so the owning FSM leaves its memory state on that same edge.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear has priority so an acknowledge never also counts as a wait cycle.
  always_comb begin
    count_d = count_q;
    timeout = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
      timeout = (count_q == LAST);
    end
  end

  // Wait counter register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/phase_controller.sv
// Multi-cycle instruction phase controller for tinycpu.
// Sequences FETCH -> DECODE -> EXEC -> [MEM_WAIT] -> WB, stalls on slow
// memory, faults on memory timeout and counts retired instructions.
// Optional single-step input is enabled by defining PHASE_CTRL_STEP_EN.
module phase_controller
  import phase_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
`ifdef PHASE_CTRL_STEP_EN
  input  logic                 step,
`endif
  phase_controller_if.master   bus,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] inst_count
);

  state_e               state_q, state_d;
  logic                 ls_q, ls_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_req;
  logic                 timeout;
  logic                 start;

`ifdef PHASE_CTRL_STEP_EN
  // A step in IDLE launches one instruction; WB returns to IDLE while run is 0.
  assign start = run | step;
`else
  assign start = run;
`endif

  assign mem_req = is_mem_state(state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (~mem_req | bus.mem_ack),
    .enable  (mem_req & ~bus.mem_ack),
    .timeout (timeout)
  );

  // Next-state logic, load/store flag latch and retirement counter.
  always_comb begin
    state_d = state_q;
    ls_d    = ls_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (timeout)          state_d = ST_FAULT;
        else if (bus.mem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ls_d    = bus.is_load_store;
        state_d = bus.is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ls_q ? ST_MEM_WAIT : ST_WB;
      end
      ST_MEM_WAIT: begin
        if (timeout)          state_d = ST_FAULT;
        else if (bus.mem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched decode flag and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ls_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ls_q    <= ls_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; ir_we alone follows mem_ack so a zero-wait fetch loads IR.
  always_comb begin
    bus.mem_req = mem_req;
    bus.ir_we   = (state_q == ST_FETCH) && bus.mem_ack;
    bus.reg_we  = (state_q == ST_WB);
    bus.pc_we   = (state_q == ST_WB);
    bus.phase   = phase_of(state_q);
    halted      = (state_q == ST_HALT);
    fault       = (state_q == ST_FAULT);
    inst_count  = cnt_q;
  end

endmodule

// File: tb/tb_phase_controller.sv
// Directed bench for phase_controller (CNT_WIDTH = 4 so counter wrap is cheap).
module tb_phase_controller;

  logic clock;
  logic reset;
  logic run;
`ifdef PHASE_CTRL_STEP_EN
  logic step;
`endif
  logic       halted;
  logic       fault;
  logic [3:0] inst_count;

  int n_vec = 0;
  int n_bad = 0;

  phase_controller_if bus ();

  phase_controller #(
    .MEM_TIMEOUT(15),
    .CNT_WIDTH  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
`ifdef PHASE_CTRL_STEP_EN
    .step       (step),
`endif
    .bus        (bus.master),
    .halted     (halted),
    .fault      (fault),
    .inst_count (inst_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view: {phase[1:0], mem_req, ir_we, reg_we, pc_we, halted, fault}
  localparam logic [7:0] S_IDLE      = 8'b00_0_0_0_0_0_0;
  localparam logic [7:0] S_FETCH     = 8'b00_1_0_0_0_0_0;
  localparam logic [7:0] S_FETCH_ACK = 8'b00_1_1_0_0_0_0;
  localparam logic [7:0] S_DEC       = 8'b01_0_0_0_0_0_0;
  localparam logic [7:0] S_EXEC      = 8'b10_0_0_0_0_0_0;
  localparam logic [7:0] S_MEMW      = 8'b10_1_0_0_0_0_0;
  localparam logic [7:0] S_WB        = 8'b11_0_0_1_1_0_0;
  localparam logic [7:0] S_HALT      = 8'b00_0_0_0_0_1_0;
  localparam logic [7:0] S_FAULT     = 8'b00_0_0_0_0_0_1;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #1;
    obs = {bus.phase, bus.mem_req, bus.ir_we, bus.reg_we, bus.pc_we, halted, fault};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: outputs got %b, expected %b", tag, obs, exp);
    end
    $display("vec %0d %s outputs=%b", n_vec, tag, obs);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    logic [3:0] e;
    e = 4'(exp);
    n_vec++;
    assert (inst_count === e) else begin
      n_bad++;
      $error("FAIL %s: inst_count got %0d, expected %0d", tag, inst_count, e);
    end
    $display("vec %0d %s inst_count=%0d", n_vec, tag, inst_count);
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b1;
    run   = 1'b0;
`ifdef PHASE_CTRL_STEP_EN
    step  = 1'b0;
`endif
    bus.mem_ack       = 1'b0;
    bus.is_load_store = 1'b0;
    bus.is_halt       = 1'b0;
    cyc();
    cyc();

    // Reset state; an ack in IDLE must not pulse ir_we.
    bus.mem_ack = 1'b1;
    chk_st("reset_idle", S_IDLE);
    chk_cnt("reset_cnt", 0);

    // ALU instruction, zero-wait memory: phases 0,1,2,3.
    reset = 1'b0;
    run   = 1'b1;
    cyc(); chk_st("alu_fetch", S_FETCH_ACK);
    cyc(); chk_st("alu_decode", S_DEC);
    cyc(); chk_st("alu_exec", S_EXEC);
    cyc(); chk_st("alu_wb", S_WB);
    chk_cnt("alu_wb_cnt", 0);
    cyc(); chk_cnt("alu_retired", 1);

    // Load/store, 3 wait cycles in MEM_WAIT, run dropped in EXEC: WB in cycle 8.
    chk_st("ls_fetch", S_FETCH_ACK);
    cyc(); bus.is_load_store = 1'b1; chk_st("ls_decode", S_DEC);
    cyc(); bus.is_load_store = 1'b0; run = 1'b0; bus.mem_ack = 1'b0;
    chk_st("ls_exec", S_EXEC);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_st("ls_wait", S_MEMW);
    end
    cyc(); bus.mem_ack = 1'b1; chk_st("ls_wait_ack", S_MEMW);
    cyc(); chk_st("ls_wb", S_WB);
    cyc(); chk_st("ls_idle_after_wb", S_IDLE);
    chk_cnt("ls_retired", 2);
    cyc(); chk_st("idle_ack_ignored", S_IDLE);

    // Reset asserted in MEM_WAIT with a concurrent ack.
    run = 1'b1;
    cyc(); chk_st("rst_fetch", S_FETCH_ACK);
    cyc(); bus.is_load_store = 1'b1; chk_st("rst_decode", S_DEC);
    cyc(); chk_st("rst_exec", S_EXEC);
    cyc(); chk_st("rst_memw", S_MEMW);
    reset = 1'b1;
    cyc(); reset = 1'b0; run = 1'b0;
    chk_st("rst_in_memw", S_IDLE);
    chk_cnt("rst_in_memw_cnt", 0);

    // Timeout boundary: ack on the 15th wait cycle still completes.
    run = 1'b1;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(); chk_st("bnd_fetch_wait", S_FETCH);
    end
    cyc(); bus.mem_ack = 1'b1; chk_st("bnd_fetch_ack15", S_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0; run = 1'b0; chk_st("bnd_decode", S_DEC);
    cyc(); chk_st("bnd_exec", S_EXEC);
    for (int i = 0; i < 14; i++) begin
      cyc(); chk_st("bnd_mem_wait", S_MEMW);
    end
    cyc(); bus.mem_ack = 1'b1; chk_st("bnd_mem_ack15", S_MEMW);
    cyc(); chk_st("bnd_wb", S_WB);
    cyc(); chk_st("bnd_idle", S_IDLE);
    chk_cnt("bnd_retired", 1);

    // Halt in DECODE: terminal, no WB, count unchanged.
    run = 1'b1;
    bus.is_load_store = 1'b0;
    bus.is_halt = 1'b1;
    cyc(); chk_st("halt_fetch", S_FETCH_ACK);
    cyc(); chk_st("halt_decode", S_DEC);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_st("halt_hold", S_HALT);
    end
    chk_cnt("halt_cnt", 1);
    bus.is_halt = 1'b0;
    reset = 1'b1;
    cyc(); reset = 1'b0; chk_st("halt_reset", S_IDLE);

    // Fault: 15 unacknowledged fetch cycles, then held for 20 cycles.
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(); chk_st("flt_fetch_wait", S_FETCH);
    end
    cyc(); chk_st("flt_enter", S_FAULT);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); chk_st("flt_hold", S_FAULT);
    end
    chk_cnt("flt_cnt", 0);
    reset = 1'b1;
    cyc(); reset = 1'b0; chk_st("flt_reset", S_IDLE);

    // Back-to-back ALU instructions across the 4-bit counter wrap.
    exp_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      cyc(); chk_st("wrap_fetch", S_FETCH_ACK);
      cyc(); chk_st("wrap_decode", S_DEC);
      cyc(); chk_st("wrap_exec", S_EXEC);
      cyc(); chk_st("wrap_wb", S_WB);
      chk_cnt("wrap_cnt", exp_cnt);
      exp_cnt = (exp_cnt + 1) % 16;
      if (k == 16) run = 1'b0;
    end
    cyc(); chk_st("wrap_idle", S_IDLE);
    chk_cnt("wrap_final", exp_cnt);

`ifdef PHASE_CTRL_STEP_EN
    // Single step from IDLE retires exactly one instruction.
    step = 1'b1;
    cyc(); step = 1'b0; chk_st("step_fetch", S_FETCH_ACK);
    cyc(); chk_st("step_decode", S_DEC);
    cyc(); chk_st("step_exec", S_EXEC);
    cyc(); chk_st("step_wb", S_WB);
    cyc(); chk_st("step_idle", S_IDLE);
    chk_cnt("step_cnt", (exp_cnt + 1) % 16);
    cyc(); chk_st("step_idle_hold", S_IDLE);
    chk_cnt("step_cnt_hold", (exp_cnt + 1) % 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_controller.md
# phase_controller

Multi-cycle instruction phase controller for the tinycpu core. It sequences every instruction through fetch, decode, execute, optional memory access and writeback, and handshakes with instruction/data memory. It drives the write enables for the instruction register, register file and PC (the sequencer's `next_pc` commit). It also produces the 2-bit phase that replaces the free-running `clock_counter`, so a slow memory stalls the core rather than corrupting it.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum wait cycles on `mem_req` without `mem_ack` before a fault.
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = execute continuously, 0 = stop at the next instruction boundary.
- `mem_ack`  in  1  memory ready; completes the current request in the same cycle.
- `is_load_store`  in  1  decoded flag; valid in DECODE.
- `is_halt`  in  1  decoded flag; valid in DECODE.
- `mem_req`  out  1  memory request, level.
- `ir_we`  out  1  instruction register load strobe.
- `reg_we`  out  1  register file write strobe.
- `pc_we`  out  1  PC commit strobe.
- `phase`  out  2  0 FETCH, 1 DECODE, 2 EXEC/MEM, 3 WB.
- `halted`  out  1  sticky; halt instruction executed.
- `fault`  out  1  sticky; memory timeout.
- `inst_count`  out  `CNT_WIDTH`  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM_WAIT, WB, HALT, FAULT.
- Reset state is IDLE. On reset every output is 0 and the wait counter is 0.
- IDLE: go to FETCH when `run` is 1.
- FETCH: `mem_req` = 1.
  - On `mem_ack`: `ir_we` = 1 for that cycle, then DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Latch `is_load_store`.
  - If `is_halt` is 1, go to HALT. No WB occurs and `inst_count` is unchanged.
  - Otherwise go to EXEC.
- EXEC: one cycle. Go to MEM_WAIT if the latched load/store flag is set, else WB.
- MEM_WAIT: `mem_req` = 1. Go to WB on `mem_ack`.
- WB: one cycle.
  - `reg_we` = 1 and `pc_we` = 1.
  - `inst_count` increments modulo 2^`CNT_WIDTH`; all-ones wraps to 0.
  - Next state is FETCH if `run` is 1, else IDLE.
- `run` falling mid-instruction has no effect until WB completes the instruction.
- Wait counter:
  - Counts cycles in which `mem_req` = 1 and `mem_ack` = 0.
  - Clears on `mem_ack` and on entry to each memory state.
  - When it reaches `MEM_TIMEOUT`, go to FAULT. `mem_req` drops the same edge.
- HALT: `halted` = 1. FAULT: `fault` = 1. Both are terminal until reset. `mem_req`, `ir_we`, `reg_we` and `pc_we` are 0 in both.
- `phase` per state:
  - FETCH = 0, DECODE = 1, EXEC and MEM_WAIT = 2, WB = 3.
  - IDLE, HALT and FAULT = 0.
- `mem_ack` outside FETCH/MEM_WAIT is ignored.

## Timing
- All outputs are registered-state decodes (Moore). Exception: `ir_we` is combinational on `mem_ack` in FETCH.
- A zero-wait `mem_ack` in the request cycle completes the handshake that cycle.
- Minimum instruction time: 4 cycles for ALU/branch, 5 cycles for load/store.
- Each wait cycle adds 1 cycle.
- Reset is synchronous and overrides everything, including a concurrent `mem_ack` or WB. The first FETCH can begin on the cycle after reset deasserts, if `run` = 1.

## Configuration
- `PHASE_CTRL_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - In IDLE with `run` = 0, a `step` = 1 cycle executes exactly one instruction, then returns to IDLE.
  - `step` is ignored outside IDLE.
  - `run` = 1 takes priority over `step`.
- `PHASE_CTRL_STEP_EN` undefined: the `step` port and its logic are absent.

## Structure
- Shared constants go in `config.v`:
  - phase encodings: `PHASE_FETCH`, `PHASE_DECODE`, `PHASE_EXEC`, `PHASE_WB`;
  - state encodings;
  - existing `DATA_WIDTH` and `PC_ADDR_WIDTH` are untouched.
- One sub-module: `mem_wait_timer`. It holds the wait counter with clear/enable inputs and a `timeout` output.

## Test plan
- Reset, then `run` = 1 and `mem_ack` tied 1 for an ALU instruction:
  - `phase` reads 0,1,2,3;
  - `ir_we` pulses in cycle 1, `reg_we`/`pc_we` in cycle 4;
  - `inst_count` = 1.
- Load/store with `mem_ack` delayed 3 cycles in MEM_WAIT: WB occurs in cycle 8, `phase` = 2 during the wait.
- `mem_ack` held 0 in FETCH: `fault` = 1 after 15 wait cycles, `mem_req` = 0, and the state is held for 20 further cycles.
- `is_halt` = 1 in DECODE: `halted` = 1, `inst_count` unchanged, no `pc_we`.
- `run` dropped in EXEC: WB still occurs, then IDLE with `phase` = 0. Reset asserted in MEM_WAIT with `mem_ack` = 1: all outputs 0 next cycle.
- Preload `inst_count` to all-ones via 65535 retirements (or with `CNT_WIDTH` = 4): it wraps to 0. With `PHASE_CTRL_STEP_EN`, a single `step` pulse retires exactly one instruction.
